fifo_pkt_reader: RTL and testbench

Read-side consumer for the project's FIFO buffer in the Ethernet test path. It drains 32-bit words from the FIFO read port and slices them into a byte stream with a valid/ready handshake for the UDP/MAC transmitter. Each packet is announced first by a length pulse. A packet is launched when the FIFO holds a full packet, or when a timeout expires with a partial packet waiting.

---
 rtl/fifo_pkt_reader.sv | 127 ++++++++++++
 tb/tb_fifo_pkt_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader.sv
// Drains 32-bit words from a FIFO read port and emits them as a big-endian byte stream,
// announcing each packet with a length pulse; launches on a full packet or on a partial-fill timeout.
module fifo_pkt_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEVEL_WIDTH = 11,
    parameter int PKT_WORDS   = 256,
    parameter int TIMEOUT     = 1000
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst_n,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic                   pkt_start,
    output logic [15:0]            pkt_byte_num,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic                   busy
);

    localparam int          TW       = $clog2(TIMEOUT);
    localparam logic [31:0] PKT_W32  = 32'(PKT_WORDS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, START, FETCH, LOAD, SEND} state_t;

    state_t         state, state_nxt;
    logic [13:0]    words_left;
    logic [TW-1:0]  tmo_cnt;
    logic [31:0]    shreg;
    logic [1:0]     byte_idx;
    logic           full_hit;
    logic           tmo_hit;
    logic [13:0]    trig_words;
    logic           hs;

    always_comb begin
        full_hit   = 32'(fifo_rd_water_level) >= PKT_W32;
        tmo_hit    = (tmo_cnt == TMO_LAST) && (|fifo_rd_water_level);
        trig_words = full_hit ? 14'(PKT_WORDS) : 14'(fifo_rd_water_level);
        hs         = tx_valid && tx_ready;
    end

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE:  if (full_hit || tmo_hit) state_nxt = START;
            START: state_nxt = FETCH;
            FETCH: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = LOAD;
                end
            end
            LOAD:  state_nxt = SEND;
            SEND: begin
                if (hs && byte_idx == 2'd3)
                    state_nxt = (words_left != 14'd0) ? FETCH : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state        <= IDLE;
            words_left   <= '0;
            tmo_cnt      <= '0;
            shreg        <= '0;
            byte_idx     <= '0;
            pkt_start    <= 1'b0;
            pkt_byte_num <= '0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            tx_last      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            pkt_start <= 1'b0;
            case (state)
                IDLE: begin
                    // Level is snapshotted here; later writes wait for the next packet.
                    if (full_hit || tmo_hit) begin
                        words_left   <= trig_words;
                        pkt_byte_num <= {trig_words, 2'b00};
                        pkt_start    <= 1'b1;
                        tmo_cnt      <= '0;
                    end else if (fifo_empty) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt != TMO_LAST) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                FETCH: begin
                    if (!fifo_empty) words_left <= words_left - 14'd1;
                end
                LOAD: begin
                    shreg    <= fifo_rd_data[31:0];
                    byte_idx <= 2'd0;
                    tx_data  <= fifo_rd_data[31:24];
                    tx_valid <= 1'b1;
                    tx_last  <= 1'b0;
                end
                SEND: begin
                    if (hs) begin
                        shreg    <= shreg << 8;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                        end else begin
                            tx_data <= shreg[23:16];
                            tx_last <= (byte_idx == 2'd2) && (words_left == 14'd0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Randomized bench for fifo_pkt_reader: queue-based FIFO model, byte scoreboard fed from
// written words, and packet length/timing rules checked on every cycle.
module tb_fifo_pkt_reader;

    localparam int PKT = 256;
    localparam int TMO = 1000;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n = 1'b0;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = '0;
    logic        fifo_empty = 1'b1;
    logic [10:0] lvl = '0;
    logic        pkt_start;
    logic [15:0] pkt_byte_num;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        tx_last;
    logic        busy;

    fifo_pkt_reader #(
        .DATA_WIDTH(32), .LEVEL_WIDTH(11), .PKT_WORDS(PKT), .TIMEOUT(TMO)
    ) dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty), .fifo_rd_water_level(lvl),
        .pkt_start(pkt_start), .pkt_byte_num(pkt_byte_num),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .busy(busy)
    );

    always #5 rd_clk = ~rd_clk;

    int          nvec = 0, nerr = 0, cyc = 0;
    logic [31:0] fq[$];
    logic [7:0]  exp_b[$];
    bit          pend_pop = 0, rdy_rand = 0, blind_arm = 0, pkt_active = 0;
    bit          prev_stall = 0, prev_last = 0;
    logic [7:0]  prev_data = '0;
    int          blind = 0, prev_level = 0, pkt_len = 0, pkt_cnt = 0, pkts_done = 0;
    int          start_cyc = 0, first_vld_cyc = -1, last_acc_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        for (int i = 3; i >= 0; i--) exp_b.push_back(w[i*8 +: 8]);
    endtask

    // One clock: inputs change only at the falling edge, outputs are observed just after.
    task automatic step();
        @(negedge rd_clk);
        cyc++;
        if (blind > 0) blind--;
        if (pend_pop && fq.size() > 0) begin
            fifo_rd_data = fq.pop_front();
            if (blind_arm) begin
                blind     = 10;
                blind_arm = 0;
            end
        end
        fifo_empty = (blind > 0) || (fq.size() == 0);
        lvl        = (blind > 0) ? 11'd0 : 11'(fq.size());
        tx_ready   = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (prev_stall) begin
            chk("stall_valid", 32'(tx_valid), 1);
            chk("stall_data", 32'(tx_data), 32'(prev_data));
            chk("stall_last", 32'(tx_last), 32'(prev_last));
        end
        if (fifo_rd_en) chk("rd_en_while_empty", 32'(fifo_empty), 0);
        if (pkt_start) begin
            chk("pkt_overlap", 32'(pkt_active), 0);
            pkt_len = ((prev_level >= PKT) ? PKT : prev_level) * 4;
            chk("pkt_byte_num", 32'(pkt_byte_num), pkt_len);
            pkt_active    = 1;
            pkt_cnt       = 0;
            start_cyc     = cyc;
            first_vld_cyc = -1;
        end
        if (tx_valid) begin
            chk("spurious_valid", 32'(pkt_active), 1);
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            if (tx_ready) begin
                if (exp_b.size() == 0) chk("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
                else chk("tx_data", 32'(tx_data), 32'(exp_b.pop_front()));
                chk("tx_last", 32'(tx_last), 32'(pkt_cnt == pkt_len - 1));
                pkt_cnt++;
                if (pkt_cnt == pkt_len) begin
                    pkt_active   = 0;
                    pkts_done++;
                    last_acc_cyc = cyc;
                end
            end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
        pend_pop   = fifo_rd_en;
        prev_level = int'(lvl);
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (pkts_done < n && k < budget) begin
            step();
            k++;
        end
        chk("pkt_done_in_time", 32'(pkts_done >= n), 1);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_rd_en"}, 32'(fifo_rd_en), 0);
        chk({pfx, "_pkt_start"}, 32'(pkt_start), 0);
        chk({pfx, "_byte_num"}, 32'(pkt_byte_num), 0);
        chk({pfx, "_tx_data"}, 32'(tx_data), 0);
        chk({pfx, "_tx_valid"}, 32'(tx_valid), 0);
        chk({pfx, "_tx_last"}, 32'(tx_last), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int t, m, k;
        rd_rst_n = 1'b0;
        step();
        step();
        chk_zero("reset");
        rd_rst_n = 1'b1;
        step();

        // Full packet, incrementing words, always ready.
        for (int i = 0; i < PKT; i++) push(32'(i));
        t = cyc + 1;
        wait_done(1, 3000);
        chk("full_start_cyc", 32'(start_cyc), 32'(t + 1));
        chk("full_first_valid", 32'(first_vld_cyc), 32'(t + 4));
        chk("full_last_cyc", 32'(last_acc_cyc), 32'(t + 4 + 6 * PKT - 3));
        chk("full_len", 32'(pkt_len), 1024);
        step();
        chk("full_busy_end", 32'(busy), 0);
        chk("full_drained", 32'(exp_b.size()), 0);

        // Partial flush after the timeout.
        repeat (3) step();
        push(32'hA1B2C3D4);
        push(32'h11223344);
        push(32'h55667788);
        t = cyc + 1;
        wait_done(2, 1200);
        chk("tmo_start_cyc", 32'(start_cyc), 32'(t + TMO));
        chk("tmo_len", 32'(pkt_len), 12);

        // Random data under random backpressure.
        step();
        rdy_rand = 1;
        for (int i = 0; i < PKT; i++) push($urandom);
        wait_done(3, 6000);
        rdy_rand = 0;
        chk("bp_len", 32'(pkt_len), 1024);
        chk("bp_drained", 32'(exp_b.size()), 0);

        // FIFO reads as empty for 10 cycles after the first pop.
        step();
        blind_arm = 1;
        for (int i = 0; i < PKT; i++) push($urandom);
        wait_done(4, 3000);
        chk("empty_len", 32'(pkt_len), 1024);
        chk("empty_duration", 32'(last_acc_cyc - start_cyc), 32'(3 + 6 * PKT - 3 + 5));

        // One word short of a full packet: waits for the timeout; late word goes next.
        step();
        for (int i = 0; i < PKT - 1; i++) push($urandom);
        t = cyc + 1;
        k = 0;
        while (!(pkt_active && pkt_cnt >= 8) && k < 1500) begin
            step();
            k++;
        end
        chk("thr_reached_send", 32'(pkt_active && pkt_cnt >= 8), 1);
        chk("thr_start_cyc", 32'(start_cyc), 32'(t + TMO));
        chk("thr_len", 32'(pkt_len), 1020);
        push(32'hCAFEF00D);
        wait_done(5, 2000);
        m = last_acc_cyc;
        wait_done(6, 1200);
        chk("thr2_start_cyc", 32'(start_cyc), 32'(m + 1 + TMO));
        chk("thr2_len", 32'(pkt_len), 4);

        // Reset in the middle of a packet, then a clean packet.
        step();
        for (int i = 0; i < PKT; i++) push($urandom);
        k = 0;
        while (!(pkt_active && pkt_cnt >= 100) && k < 1500) begin
            step();
            k++;
        end
        chk("mid_reached_byte100", 32'(pkt_cnt >= 100), 1);
        rd_rst_n   = 1'b0;
        fq.delete();
        exp_b.delete();
        pkt_active = 0;
        pend_pop   = 0;
        prev_stall = 0;
        blind      = 0;
        step();
        chk_zero("mid_rst");
        rd_rst_n = 1'b1;
        step();
        for (int i = 0; i < PKT; i++) push($urandom);
        wait_done(7, 3000);
        chk("post_rst_len", 32'(pkt_len), 1024);
        chk("post_rst_drained", 32'(exp_b.size()), 0);
        step();
        chk("post_rst_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
